ibex_fp_regfile_wb: RTL and testbench

- 32-entry floating-point register file that receives FP writebacks at the far end of the writeback path.
  - Writeback-stage port: `we_wb_i`, the writeback stage's FP write strobe (unbacked, always accepted).
  - FPU result port: multicycle results, valid/ready handshake.
- A collision buffer absorbs simultaneous writes and preserves write-after-write ordering.
- Three combinational read ports (rs1/rs2/rs3 for FMA) feed the ID stage.

---
 rtl/ibex_fp_regfile_wb.sv | 164 ++++++++++++++++
 tb/tb_ibex_fp_regfile_wb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fp_regfile_wb.sv
// ibex_fp_regfile_wb
// 32-entry floating-point register file at the far end of the writeback path.
// The writeback stage write is never stalled and owns the array write port.
// FPU results arriving in the same cycle are parked in a small collision
// buffer, which drains into the array on cycles with no writeback write.
// Write-after-write order is kept: a writeback write kills older buffered
// writes to the same register. Reads see the youngest live buffered value.
//
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   we_wb_i, waddr_wb_i, wdata_wb_i     writeback-stage write (always accepted)
//   fpu_valid_i, fpu_ready_o,
//   fpu_waddr_i, fpu_wdata_i            FPU result valid/ready handshake
//   raddr_{a,b,c}_i, rdata_{a,b,c}_o    combinational read ports (rs1/rs2/rs3)
//   buf_empty_o, buf_cnt_o              collision buffer empty flag / occupancy
module ibex_fp_regfile_wb #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned BufDepth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_wb_i,
  input  logic [4:0]           waddr_wb_i,
  input  logic [DataWidth-1:0] wdata_wb_i,
  input  logic                 fpu_valid_i,
  output logic                 fpu_ready_o,
  input  logic [4:0]           fpu_waddr_i,
  input  logic [DataWidth-1:0] fpu_wdata_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [4:0]           raddr_c_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic [DataWidth-1:0] rdata_c_o,
  output logic                 buf_empty_o,
  output logic [2:0]           buf_cnt_o
);

  // Pointer storage is sized to a power of two; only slots 0..BufDepth-1 are used.
  localparam int unsigned PtrW      = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam int unsigned Slots     = 2 ** PtrW;
  localparam logic [2:0]  BufDepthC = 3'(BufDepth);

  logic [DataWidth-1:0] rf_q    [32];
  logic [4:0]           baddr_q [Slots];
  logic [DataWidth-1:0] bdata_q [Slots];
  logic [Slots-1:0]     live_q, live_d;
  logic [PtrW-1:0]      head_q, tail_q;
  logic [2:0]           cnt_q;

  logic                 buf_nonempty;
  logic                 fpu_acc;
  logic                 push, pop, direct;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [DataWidth-1:0] rf_wdata;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BufDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Oldest-to-youngest scan so the youngest live match wins.
  function automatic logic [DataWidth-1:0] read_port(input logic [4:0] ra);
    logic [DataWidth-1:0] r;
    logic [PtrW-1:0]      p;
    r = rf_q[ra];
    p = head_q;
    for (int k = 0; k < int'(BufDepth); k++) begin
      if ((3'(k) < cnt_q) && live_q[p] && (baddr_q[p] == ra)) r = bdata_q[p];
      p = ptr_inc(p);
    end
    return r;
  endfunction

  assign buf_nonempty = (cnt_q != 3'd0);
  // Ready depends only on registered occupancy; a pop this cycle does not raise it.
  assign fpu_ready_o  = (cnt_q < BufDepthC);
  assign buf_empty_o  = ~buf_nonempty;
  assign buf_cnt_o    = cnt_q;

  assign fpu_acc = fpu_valid_i & fpu_ready_o;
  // With a writeback write or older buffered work pending, the FPU result must queue.
  assign push    = fpu_acc & (we_wb_i | buf_nonempty);
  assign pop     = ~we_wb_i & buf_nonempty;
  assign direct  = fpu_acc & ~we_wb_i & ~buf_nonempty;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (we_wb_i) begin
      rf_we    = 1'b1;
      rf_waddr = waddr_wb_i;
      rf_wdata = wdata_wb_i;
    end else if (pop) begin
      // Dead heads are popped without touching the array.
      rf_we    = live_q[head_q];
      rf_waddr = baddr_q[head_q];
      rf_wdata = bdata_q[head_q];
    end else if (direct) begin
      rf_we    = 1'b1;
      rf_waddr = fpu_waddr_i;
      rf_wdata = fpu_wdata_i;
    end
  end

  // Kill first, then mark the new tail live: a same-cycle FPU push to the
  // killed address is younger than the writeback write and must survive.
  always_comb begin
    live_d = live_q;
    for (int s = 0; s < int'(Slots); s++) begin
      if (we_wb_i && (baddr_q[PtrW'(s)] == waddr_wb_i)) live_d[PtrW'(s)] = 1'b0;
    end
    if (push) live_d[tail_q] = 1'b1;
  end

  always_comb begin
    rdata_a_o = read_port(raddr_a_i);
    rdata_b_o = read_port(raddr_b_i);
    rdata_c_o = read_port(raddr_c_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      live_q <= live_d;
      if (push) tail_q <= ptr_inc(tail_q);
      if (pop)  head_q <= ptr_inc(head_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Buffer payload carries no reset; liveness and occupancy qualify it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      baddr_q[tail_q] <= fpu_waddr_i;
      bdata_q[tail_q] <= fpu_wdata_i;
    end
  end

  a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (cnt_q == BufDepthC)));
  a_one_write : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({we_wb_i, pop & live_q[head_q], direct}));
  a_fpu_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fpu_valid_i && !fpu_ready_o) |=> (fpu_valid_i && $stable(fpu_waddr_i) && $stable(fpu_wdata_i)));

endmodule

// File: tb/tb_ibex_fp_regfile_wb.sv
// Bench for ibex_fp_regfile_wb: directed stimulus, a queue-based reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_ibex_fp_regfile_wb;

  localparam int BUF = 2;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        we_wb_i;
  logic [4:0]  waddr_wb_i;
  logic [31:0] wdata_wb_i;
  logic        fpu_valid_i;
  logic        fpu_ready_o;
  logic [4:0]  fpu_waddr_i;
  logic [31:0] fpu_wdata_i;
  logic [4:0]  raddr_a_i, raddr_b_i, raddr_c_i;
  logic [31:0] rdata_a_o, rdata_b_o, rdata_c_o;
  logic        buf_empty_o;
  logic [2:0]  buf_cnt_o;

  int n_vec = 0;
  int n_bad = 0;

  ibex_fp_regfile_wb #(.DataWidth(32), .BufDepth(BUF)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .we_wb_i     (we_wb_i),
    .waddr_wb_i  (waddr_wb_i),
    .wdata_wb_i  (wdata_wb_i),
    .fpu_valid_i (fpu_valid_i),
    .fpu_ready_o (fpu_ready_o),
    .fpu_waddr_i (fpu_waddr_i),
    .fpu_wdata_i (fpu_wdata_i),
    .raddr_a_i   (raddr_a_i),
    .raddr_b_i   (raddr_b_i),
    .raddr_c_i   (raddr_c_i),
    .rdata_a_o   (rdata_a_o),
    .rdata_b_o   (rdata_b_o),
    .rdata_c_o   (rdata_c_o),
    .buf_empty_o (buf_empty_o),
    .buf_cnt_o   (buf_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus an ordered list of pending
  // FPU writes, oldest at the front.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ent_t;

  logic [31:0] m_rf [32];
  ent_t        m_q [$];

  initial for (int i = 0; i < 32; i++) m_rf[i] = '0;

  function automatic logic [31:0] m_read(input logic [4:0] ra);
    for (int i = m_q.size() - 1; i >= 0; i--)
      if (m_q[i].live && m_q[i].a == ra) return m_q[i].d;
    return m_rf[ra];
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_q.delete();
    end else begin
      bit   acc;
      ent_t e;
      acc = fpu_valid_i && (m_q.size() < BUF);
      if (we_wb_i) begin
        m_rf[waddr_wb_i] = wdata_wb_i;
        foreach (m_q[i]) if (m_q[i].a == waddr_wb_i) m_q[i].live = 1'b0;
        if (acc) m_q.push_back('{fpu_waddr_i, fpu_wdata_i, 1'b1});
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        if (e.live) m_rf[e.a] = e.d;
        if (acc) m_q.push_back('{fpu_waddr_i, fpu_wdata_i, 1'b1});
      end else if (acc) begin
        m_rf[fpu_waddr_i] = fpu_wdata_i;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("m_ready", 32'(fpu_ready_o), 32'(m_q.size() < BUF));
      chk("m_empty", 32'(buf_empty_o), 32'(m_q.size() == 0));
      chk("m_cnt",   32'(buf_cnt_o),   32'(m_q.size()));
      chk("m_rdata_a", rdata_a_o, m_read(raddr_a_i));
      chk("m_rdata_b", rdata_b_o, m_read(raddr_b_i));
      chk("m_rdata_c", rdata_c_o, m_read(raddr_c_i));
    end
  end

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic fv, input logic [4:0] fa, input logic [31:0] fd);
    we_wb_i     = we;
    waddr_wb_i  = wa;
    wdata_wb_i  = wd;
    fpu_valid_i = fv;
    fpu_waddr_i = fa;
    fpu_wdata_i = fd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    raddr_a_i = 5; raddr_b_i = 5; raddr_c_i = 5;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdata_a", rdata_a_o, 32'h0);
    chk("rst_rdata_b", rdata_b_o, 32'h0);
    chk("rst_rdata_c", rdata_c_o, 32'h0);
    chk("rst_ready", 32'(fpu_ready_o), 32'd1);
    chk("rst_empty", 32'(buf_empty_o), 32'd1);
    chk("rst_cnt", 32'(buf_cnt_o), 32'd0);
    next_cycle();
    rst_ni = 1'b1;

    // Direct FPU write with the buffer empty
    drive(0, 0, 0, 1, 3, 32'h3F80_0000);
    raddr_a_i = 3;
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("direct_cnt", 32'(buf_cnt_o), 32'd0);
    chk("direct_f3", rdata_a_o, 32'h3F80_0000);

    // Collision: WB f1, FPU f2 buffered
    next_cycle();
    drive(1, 1, 32'h11, 1, 2, 32'h22);
    raddr_a_i = 1; raddr_b_i = 2;
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("coll_f1", rdata_a_o, 32'h11);
    chk("coll_f2_buf", rdata_b_o, 32'h22);
    chk("coll_cnt", 32'(buf_cnt_o), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("coll_drain_cnt", 32'(buf_cnt_o), 32'd0);
    chk("coll_f2_arr", rdata_b_o, 32'h22);

    // Fill the buffer, then hold the refused request
    raddr_a_i = 20; raddr_b_i = 21; raddr_c_i = 22;
    next_cycle();
    drive(1, 10, 32'hA0, 1, 20, 32'hB0);
    @(negedge clk);
    chk("fill_c1_ready", 32'(fpu_ready_o), 32'd1);
    next_cycle();
    drive(1, 11, 32'hA1, 1, 21, 32'hB1);
    @(negedge clk);
    chk("fill_c2_ready", 32'(fpu_ready_o), 32'd1);
    next_cycle();
    drive(1, 12, 32'hA2, 1, 22, 32'hB2);
    @(negedge clk);
    chk("fill_c3_ready", 32'(fpu_ready_o), 32'd0);
    chk("fill_c3_cnt", 32'(buf_cnt_o), 32'd2);
    next_cycle();
    drive(0, 0, 0, 1, 22, 32'hB2);
    @(negedge clk);
    chk("fill_c4_ready", 32'(fpu_ready_o), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("fill_c5_ready", 32'(fpu_ready_o), 32'd1);
    chk("fill_c5_cnt", 32'(buf_cnt_o), 32'd1);
    chk("fill_c5_f20", rdata_a_o, 32'hB0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("fill_c6_cnt", 32'(buf_cnt_o), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("fill_done_cnt", 32'(buf_cnt_o), 32'd0);
    chk("fill_f21", rdata_b_o, 32'hB1);
    chk("fill_f22", rdata_c_o, 32'hB2);

    // Kill: buffered f4=AA overwritten by a later WB f4=BB
    raddr_a_i = 4;
    next_cycle();
    drive(1, 1, 32'h55, 1, 4, 32'hAA);
    next_cycle();
    drive(1, 4, 32'hBB, 0, 0, 0);
    @(negedge clk);
    chk("kill_pre_f4", rdata_a_o, 32'hAA);
    chk("kill_pre_cnt", 32'(buf_cnt_o), 32'd1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("kill_dead_f4", rdata_a_o, 32'hBB);
    chk("kill_dead_cnt", 32'(buf_cnt_o), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("kill_drain_cnt", 32'(buf_cnt_o), 32'd0);
    chk("kill_drain_f4", rdata_a_o, 32'hBB);

    // Same-cycle same-address: FPU value is younger
    raddr_a_i = 7;
    next_cycle();
    drive(1, 7, 32'h1, 1, 7, 32'h2);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("same_buf_f7", rdata_a_o, 32'h2);
    chk("same_buf_cnt", 32'(buf_cnt_o), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("same_drain_f7", rdata_a_o, 32'h2);
    chk("same_drain_cnt", 32'(buf_cnt_o), 32'd0);

    // Reset with a buffered entry pending
    raddr_b_i = 9;
    next_cycle();
    drive(1, 8, 32'h8, 1, 9, 32'h99);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_cnt", 32'(buf_cnt_o), 32'd1);
    chk("mid_f9", rdata_b_o, 32'h99);
    #1 rst_ni = 1'b0;
    #1;
    chk("mrst_cnt", 32'(buf_cnt_o), 32'd0);
    chk("mrst_empty", 32'(buf_empty_o), 32'd1);
    chk("mrst_ready", 32'(fpu_ready_o), 32'd1);
    chk("mrst_f9", rdata_b_o, 32'h0);
    for (int i = 0; i < 32; i++) begin
      raddr_a_i = 5'(i);
      #1 chk("mrst_sweep", rdata_a_o, 32'h0);
    end
    next_cycle();
    rst_ni = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
